// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a scanned 4-digit 7-segment bus: rebuilds mX/mU/sX/sU BCD digits.
// Optional build macro SEG_DECODE_HEX_EN adds A-F glyphs to the decode table.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] shape,
  input  logic [3:0] choose_light_sig,
  output logic [3:0] mX,
  output logic [3:0] mU,
  output logic [3:0] sX,
  output logic [3:0] sU,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       signal_lost
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_CAPTURED} state_t;

  state_t        state_q, state_d;
  logic [6:0]    shape_q;
  logic [3:0]    sel_q;
  logic [6:0]    seg_n, prev_seg_q;
  logic [3:0]    sel_n, prev_sel_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitmap_q, bitmap_d;
  logic [3:0]    slot_val_q [4];
  logic [3:0]    slot_err_q;
  logic [TW-1:0] to_cnt_q;
  logic          sel_valid, same, capture, frame_done;
  logic [3:0]    dec_val;
  logic          dec_err;
  logic          unused_dp;

  assign unused_dp = shape[7];

  assign seg_n      = SEG_ACTIVE_LOW ? ~shape_q : shape_q;
  assign sel_n      = SEL_ACTIVE_LOW ? ~sel_q : sel_q;
  assign sel_valid  = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
  assign same       = (sel_n == prev_sel_q) && (seg_n == prev_seg_q);
  assign frame_done = (bitmap_q == 4'hF);

  always_comb begin
    dec_err = 1'b0;
    case (seg_n)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
`ifdef SEG_DECODE_HEX_EN
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
`endif
      default: begin
        dec_val = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  // Dwell decision: a held glyph is captured once, on the edge its count hits STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!sel_valid) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!(state_q == S_CAPTURED && same)) begin
      cnt_d = (state_q == S_DWELL && same) ? cnt_q + CW'(1) : CW'(1);
      if (cnt_d == STABLE_C) begin
        capture = 1'b1;
        state_d = S_CAPTURED;
      end else begin
        state_d = S_DWELL;
      end
    end
  end

  always_comb begin
    bitmap_d = frame_done ? 4'h0 : bitmap_q;
    if (capture) bitmap_d = bitmap_d | sel_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shape_q     <= '0;
      sel_q       <= '0;
      prev_seg_q  <= '0;
      prev_sel_q  <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitmap_q    <= '0;
      slot_err_q  <= '0;
      for (int i = 0; i < 4; i++) slot_val_q[i] <= '0;
      mX          <= '0;
      mU          <= '0;
      sX          <= '0;
      sU          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      signal_lost <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      shape_q    <= shape[6:0];
      sel_q      <= choose_light_sig;
      prev_seg_q <= seg_n;
      prev_sel_q <= sel_n;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitmap_q   <= bitmap_d;
      for (int i = 0; i < 4; i++) begin
        if (capture && sel_n[i]) begin
          slot_val_q[i] <= dec_val;
          slot_err_q[i] <= dec_err;
        end
      end
      frame_valid <= frame_done;
      if (frame_done) begin
        mX          <= slot_val_q[3];
        mU          <= slot_val_q[2];
        sX          <= slot_val_q[1];
        sU          <= slot_val_q[0];
        frame_err   <= |slot_err_q;
        to_cnt_q    <= '0;
        signal_lost <= 1'b0;
      end else begin
        if (to_cnt_q != {TW{1'b1}}) to_cnt_q <= to_cnt_q + TW'(1);
        if (to_cnt_q + TW'(1) >= TIMEOUT_C) signal_lost <= 1'b1;
      end
    end
  end

endmodule
